id_ex_pipeline: RTL and testbench

- Decode-to-execute pipeline stage sitting directly downstream of the register file.
- Takes register-file read data RD1/RD2 plus decoded control, resolves operands, and registers them for the execute stage.
- Operand resolution covers R15 (PC) substitution and MEM/WB forwarding.
- Detects load-use hazards (stall + bubble) and applies branch flushes; keeps saturating stall/flush counters for debug.

---
 rtl/id_ex_pipeline_if.sv | 56 +++++
 rtl/id_ex_pipeline.sv | 121 ++++++++++++
 tb/tb_id_ex_pipeline.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipeline_if.sv
// ID/EX stage bus: decode inputs, MEM/WB forwarding sources, flush, and the
// registered EX-side outputs plus hazard/debug signals.
interface id_ex_pipeline_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_ra1;
  logic [REG_AW-1:0] id_ra2;
  logic              id_use1;
  logic              id_use2;
  logic [REG_AW-1:0] id_wa;
  logic              id_we;
  logic              id_mem_read;
  logic [DATA_W-1:0] id_imm;
  logic [7:0]        id_ctrl;
  logic [DATA_W-1:0] id_pc8;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              mem_we;
  logic [REG_AW-1:0] mem_wa;
  logic [DATA_W-1:0] mem_result;
  logic              wb_we;
  logic [REG_AW-1:0] wb_wa;
  logic [DATA_W-1:0] wb_result;
  logic              flush;

  logic              ex_valid;
  logic              ex_we;
  logic              ex_mem_read;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_wa;
  logic [7:0]        ex_ctrl;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, id_ra1, id_ra2, id_use1, id_use2, id_wa, id_we,
           id_mem_read, id_imm, id_ctrl, id_pc8, rd1, rd2,
           mem_we, mem_wa, mem_result, wb_we, wb_wa, wb_result, flush,
    input  ex_valid, ex_we, ex_mem_read, ex_op1, ex_op2, ex_imm, ex_wa,
           ex_ctrl, stall, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_ra1, id_ra2, id_use1, id_use2, id_wa, id_we,
           id_mem_read, id_imm, id_ctrl, id_pc8, rd1, rd2,
           mem_we, mem_wa, mem_result, wb_we, wb_wa, wb_result, flush,
    output ex_valid, ex_we, ex_mem_read, ex_op1, ex_op2, ex_imm, ex_wa,
           ex_ctrl, stall, stall_count, flush_count
  );
endinterface

// File: rtl/id_ex_pipeline.sv
// Decode-to-execute stage: resolves operands (R15 / MEM / WB forwarding),
// detects load-use hazards, applies branch flushes, keeps debug counters.
module id_ex_pipeline #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  id_ex_pipeline_if.slave bus
);

  localparam logic [REG_AW-1:0] PC_REG = REG_AW'(15);

  logic              ex_valid_q;
  logic              ex_we_q;
  logic              ex_mem_read_q;
  logic [DATA_W-1:0] ex_op1_q;
  logic [DATA_W-1:0] ex_op2_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [REG_AW-1:0] ex_wa_q;
  logic [7:0]        ex_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              hazard;
  logic              stall_int;
  logic [DATA_W-1:0] op1_d;
  logic [DATA_W-1:0] op2_d;

  // R15 is checked first, so MEM/WB writes to R15 can never be forwarded.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_AW-1:0] ra,
    input logic [DATA_W-1:0] rd,
    input logic [DATA_W-1:0] pc8,
    input logic              m_we,
    input logic [REG_AW-1:0] m_wa,
    input logic [DATA_W-1:0] m_res,
    input logic              w_we,
    input logic [REG_AW-1:0] w_wa,
    input logic [DATA_W-1:0] w_res
  );
    logic [DATA_W-1:0] r;
    if (ra == PC_REG)               r = pc8;
    else if (m_we && (m_wa == ra))  r = m_res;
    else if (w_we && (w_wa == ra))  r = w_res;
    else                            r = rd;
    return r;
  endfunction

  always_comb begin
    op1_d = resolve(bus.id_ra1, bus.rd1, bus.id_pc8,
                    bus.mem_we, bus.mem_wa, bus.mem_result,
                    bus.wb_we, bus.wb_wa, bus.wb_result);
    op2_d = resolve(bus.id_ra2, bus.rd2, bus.id_pc8,
                    bus.mem_we, bus.mem_wa, bus.mem_result,
                    bus.wb_we, bus.wb_wa, bus.wb_result);
  end

  always_comb begin
    hazard = ex_valid_q && ex_mem_read_q && ex_we_q && (ex_wa_q != PC_REG) &&
             bus.id_valid &&
             ((bus.id_use1 && (bus.id_ra1 == ex_wa_q)) ||
              (bus.id_use2 && (bus.id_ra2 == ex_wa_q)));
    stall_int = hazard && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_we_q       <= 1'b0;
      ex_mem_read_q <= 1'b0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      ex_imm_q      <= '0;
      ex_wa_q       <= '0;
      ex_ctrl_q     <= '0;
    end else if (bus.flush || hazard) begin
      // Bubble: only the control bits clear; operand fields hold.
      ex_valid_q    <= 1'b0;
      ex_we_q       <= 1'b0;
      ex_mem_read_q <= 1'b0;
    end else begin
      ex_valid_q    <= bus.id_valid;
      ex_we_q       <= bus.id_we && bus.id_valid;
      ex_mem_read_q <= bus.id_mem_read && bus.id_valid;
      ex_op1_q      <= op1_d;
      ex_op2_q      <= op2_d;
      ex_imm_q      <= bus.id_imm;
      ex_wa_q       <= bus.id_wa;
      ex_ctrl_q     <= bus.id_ctrl;
    end
  end

  // Flush takes precedence, so a simultaneous hazard is not counted as a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.flush) begin
      if (bus.id_valid && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end else if (hazard) begin
      if (stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_we       = ex_we_q;
  assign bus.ex_mem_read = ex_mem_read_q;
  assign bus.ex_op1      = ex_op1_q;
  assign bus.ex_op2      = ex_op2_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_wa       = ex_wa_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.stall       = stall_int;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline.sv
// Directed bench for id_ex_pipeline; a second narrow-counter instance
// exercises counter saturation within a short run.
module tb_id_ex_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
  id_ex_pipeline_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  sb ();

  id_ex_pipeline #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  id_ex_pipeline #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sb.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.id_valid = 0; bus.id_ra1 = 0; bus.id_ra2 = 0; bus.id_use1 = 0;
    bus.id_use2 = 0; bus.id_wa = 0; bus.id_we = 0; bus.id_mem_read = 0;
    bus.id_imm = 0; bus.id_ctrl = 0; bus.id_pc8 = 0; bus.rd1 = 0; bus.rd2 = 0;
    bus.mem_we = 0; bus.mem_wa = 0; bus.mem_result = 0;
    bus.wb_we = 0; bus.wb_wa = 0; bus.wb_result = 0; bus.flush = 0;
  endtask

  task automatic set_idle_small();
    sb.id_valid = 0; sb.id_ra1 = 0; sb.id_ra2 = 0; sb.id_use1 = 0;
    sb.id_use2 = 0; sb.id_wa = 0; sb.id_we = 0; sb.id_mem_read = 0;
    sb.id_imm = 0; sb.id_ctrl = 0; sb.id_pc8 = 0; sb.rd1 = 0; sb.rd2 = 0;
    sb.mem_we = 0; sb.mem_wa = 0; sb.mem_result = 0;
    sb.wb_we = 0; sb.wb_wa = 0; sb.wb_result = 0; sb.flush = 0;
  endtask

  // Drive a load to r2 into decode (captured into EX on the next edge).
  task automatic drive_load_r2();
    set_idle();
    bus.id_valid = 1; bus.id_we = 1; bus.id_mem_read = 1; bus.id_wa = 2;
  endtask

  task automatic test_reset();
    rst = 1;
    set_idle();
    bus.id_valid = 1; bus.id_ra1 = 3; bus.rd1 = 32'h77; bus.id_use1 = 1; bus.id_we = 1;
    tick(); tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.ex_op1 !== 32'h0) begin errors++; $display("FAIL reset_ex_op1: got %h expected 0", bus.ex_op1); end
    checks++; if (bus.ex_we !== 1'b0) begin errors++; $display("FAIL reset_ex_we: got %b expected 0", bus.ex_we); end
    checks++; if (bus.stall_count !== 16'h0) begin errors++; $display("FAIL reset_stall_count: got %h expected 0", bus.stall_count); end
    checks++; if (bus.flush_count !== 16'h0) begin errors++; $display("FAIL reset_flush_count: got %h expected 0", bus.flush_count); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    rst = 0;
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL first_capture_valid: got %b expected 1", bus.ex_valid); end
    checks++; if (bus.ex_op1 !== 32'h77) begin errors++; $display("FAIL first_capture_op1: got %h expected 00000077", bus.ex_op1); end
  endtask

  task automatic test_plain_capture();
    set_idle();
    bus.id_valid = 1; bus.id_ra1 = 3; bus.rd1 = 32'h11; bus.id_ra2 = 4; bus.rd2 = 32'h22;
    bus.id_use1 = 1; bus.id_use2 = 1; bus.id_we = 1; bus.id_wa = 7;
    bus.id_imm = 32'h55; bus.id_ctrl = 8'hA5;
    tick();
    checks++; if (bus.ex_op1 !== 32'h11) begin errors++; $display("FAIL plain_op1: got %h expected 00000011", bus.ex_op1); end
    checks++; if (bus.ex_op2 !== 32'h22) begin errors++; $display("FAIL plain_op2: got %h expected 00000022", bus.ex_op2); end
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL plain_valid: got %b expected 1", bus.ex_valid); end
    checks++; if (bus.ex_we !== 1'b1) begin errors++; $display("FAIL plain_we: got %b expected 1", bus.ex_we); end
    checks++; if (bus.ex_mem_read !== 1'b0) begin errors++; $display("FAIL plain_mem_read: got %b expected 0", bus.ex_mem_read); end
    checks++; if (bus.ex_wa !== 5'd7) begin errors++; $display("FAIL plain_wa: got %0d expected 7", bus.ex_wa); end
    checks++; if (bus.ex_imm !== 32'h55) begin errors++; $display("FAIL plain_imm: got %h expected 00000055", bus.ex_imm); end
    checks++; if (bus.ex_ctrl !== 8'hA5) begin errors++; $display("FAIL plain_ctrl: got %h expected a5", bus.ex_ctrl); end
    // Invalid decode slot captures a bubble even with id_we set
    bus.id_valid = 0;
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.ex_we !== 1'b0) begin errors++; $display("FAIL bubble_we: got %b expected 0", bus.ex_we); end
  endtask

  task automatic test_forward();
    set_idle();
    bus.id_valid = 1; bus.id_ra1 = 5; bus.rd1 = 32'h1; bus.id_use1 = 1;
    bus.wb_we = 1; bus.wb_wa = 5; bus.wb_result = 32'hB;
    bus.mem_we = 1; bus.mem_wa = 5; bus.mem_result = 32'hA;
    tick();
    checks++; if (bus.ex_op1 !== 32'hA) begin errors++; $display("FAIL fwd_mem_priority: got %h expected 0000000a", bus.ex_op1); end
    bus.mem_we = 0;
    tick();
    checks++; if (bus.ex_op1 !== 32'hB) begin errors++; $display("FAIL fwd_wb: got %h expected 0000000b", bus.ex_op1); end
    bus.wb_wa = 6;
    tick();
    checks++; if (bus.ex_op1 !== 32'h1) begin errors++; $display("FAIL fwd_none: got %h expected 00000001", bus.ex_op1); end
  endtask

  task automatic test_r15();
    set_idle();
    bus.id_valid = 1; bus.id_ra2 = 15; bus.id_use2 = 1; bus.id_pc8 = 32'h108; bus.rd2 = 32'h99;
    bus.mem_we = 1; bus.mem_wa = 15; bus.mem_result = 32'hDEAD;
    bus.wb_we = 1; bus.wb_wa = 15; bus.wb_result = 32'hBEEF;
    tick();
    checks++; if (bus.ex_op2 !== 32'h108) begin errors++; $display("FAIL r15_op2: got %h expected 00000108", bus.ex_op2); end
  endtask

  task automatic test_load_use();
    drive_load_r2();
    tick();
    set_idle();
    bus.id_valid = 1; bus.id_ra1 = 2; bus.id_use1 = 1; bus.rd1 = 32'h333;
    bus.id_we = 1; bus.id_wa = 8;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b expected 1", bus.stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL loaduse_bubble: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL loaduse_stall_count: got %0d expected 1", bus.stall_count); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL loaduse_stall_one_cycle: got %b expected 0", bus.stall); end
    bus.mem_we = 1; bus.mem_wa = 2; bus.mem_result = 32'h4444;
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL loaduse_release_valid: got %b expected 1", bus.ex_valid); end
    checks++; if (bus.ex_op1 !== 32'h4444) begin errors++; $display("FAIL loaduse_mem_fwd: got %h expected 00004444", bus.ex_op1); end

    // Same register on an unused source: no stall
    drive_load_r2();
    tick();
    set_idle();
    bus.id_valid = 1; bus.id_ra1 = 2; bus.id_ra2 = 2; bus.rd1 = 32'h5;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL unused_no_stall: got %b expected 0", bus.stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL unused_capture: got %b expected 1", bus.ex_valid); end
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL unused_stall_count: got %0d expected 1", bus.stall_count); end

    // Load to R15 in EX never stalls
    set_idle();
    bus.id_valid = 1; bus.id_we = 1; bus.id_mem_read = 1; bus.id_wa = 15;
    tick();
    set_idle();
    bus.id_valid = 1; bus.id_ra1 = 15; bus.id_use1 = 1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL r15_load_no_stall: got %b expected 0", bus.stall); end
  endtask

  task automatic test_flush_hazard();
    rst = 1; tick(); rst = 0;
    drive_load_r2();
    tick();
    set_idle();
    bus.id_valid = 1; bus.id_ra2 = 2; bus.id_use2 = 1; bus.id_wa = 9; bus.flush = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush_stall_visible: got %b expected 1", bus.stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble: got %b expected 0", bus.ex_valid); end
    checks++; if (bus.flush_count !== 16'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", bus.flush_count); end
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL flush_stall_count: got %0d expected 0", bus.stall_count); end
    checks++; if (bus.ex_wa !== 5'd2) begin errors++; $display("FAIL flush_hold_wa: got %0d expected 2", bus.ex_wa); end
    bus.id_valid = 0;
    tick();
    checks++; if (bus.flush_count !== 16'd1) begin errors++; $display("FAIL flush_invalid_nocount: got %0d expected 1", bus.flush_count); end
  endtask

  task automatic test_reset_mid_stall();
    bus.flush = 0;
    drive_load_r2();
    tick();
    set_idle();
    bus.id_valid = 1; bus.id_ra1 = 2; bus.id_use1 = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL midstall_pre: got %b expected 1", bus.stall); end
    #2;
    rst = 1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL midstall_async_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL midstall_async_valid: got %b expected 0", bus.ex_valid); end
    tick();
    rst = 0;
    set_idle();
  endtask

  task automatic test_saturation();
    set_idle_small();
    // Decode is a load to r2 that also reads r2: stalls whenever EX holds it.
    sb.id_valid = 1; sb.id_we = 1; sb.id_mem_read = 1; sb.id_wa = 2;
    sb.id_ra1 = 2; sb.id_use1 = 1;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      tick();
    end
    checks++; if (sb.stall_count !== 4'hF) begin errors++; $display("FAIL sat_stall_reach_max: got %h expected f", sb.stall_count); end
    checks++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL sat_stall_pending: got %b expected 1", sb.stall); end
    tick();
    checks++; if (sb.stall_count !== 4'hF) begin errors++; $display("FAIL sat_stall_no_wrap: got %h expected f", sb.stall_count); end
    sb.flush = 1;
    for (int i = 0; i < 16; i++) tick();
    checks++; if (sb.flush_count !== 4'hF) begin errors++; $display("FAIL sat_flush_no_wrap: got %h expected f", sb.flush_count); end
    checks++; if (sb.stall_count !== 4'hF) begin errors++; $display("FAIL sat_stall_after_flush: got %h expected f", sb.stall_count); end
    set_idle_small();
  endtask

  initial begin
    set_idle();
    set_idle_small();
    test_reset();
    test_plain_capture();
    test_forward();
    test_r15();
    test_load_use();
    test_flush_hazard();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
